// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: each note-on/off event is scanned against every voice slot,
// then retriggers, allocates or steals a voice; panic silences all gates.
module voice_allocator #(
  parameter int VOICES  = 4,
  parameter int KEYBITS = 4,
  parameter int INCBITS = 16,
  parameter int AGEBITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [KEYBITS-1:0]         ev_key,
  input  logic [INCBITS-1:0]         ev_increment,
  input  logic                       panic,
  output logic [VOICES-1:0]          gate,
  output logic [VOICES-1:0]          trig,
  output logic [VOICES*INCBITS-1:0]  voice_increment,
  output logic [VOICES*KEYBITS-1:0]  voice_key,
  output logic                       steal,
  output logic [3:0]                 active_count
);

  localparam int IDXW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [AGEBITS-1:0] AGE_MAX = '1;

  typedef logic [IDXW-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} state_t;

  state_t               r_state;
  state_t               w_state_next;
  idx_t                 r_idx;
  logic                 r_ev_on;
  logic [KEYBITS-1:0]   r_ev_key;
  logic [INCBITS-1:0]   r_ev_inc;

  logic                 r_match_vld;
  idx_t                 r_match_idx;
  logic                 r_free_vld;
  idx_t                 r_free_idx;
  logic                 r_old_vld;
  idx_t                 r_old_idx;
  logic [AGEBITS-1:0]   r_old_age;

  logic [VOICES-1:0]    r_gate;
  logic [VOICES-1:0]    r_trig;
  logic                 r_steal;
  logic [3:0]           r_active;
  logic [KEYBITS-1:0]   r_key [VOICES];
  logic [INCBITS-1:0]   r_inc [VOICES];
  logic [AGEBITS-1:0]   r_age [VOICES];

  logic                 w_accept;
  logic                 w_last;
  logic                 w_scan_gate;
  logic                 w_scan_hit;
  idx_t                 w_tgt;
  logic                 w_steal_path;

  function automatic logic [3:0] popcount(input logic [VOICES-1:0] g);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < VOICES; i++) c = c + {3'b000, g[i]};
    return c;
  endfunction

  // ---------------- FSM ----------------
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    ev_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ev_ready = ~panic;
        if (ev_valid && !panic) w_state_next = S_SCAN;
      end
      S_SCAN:  if (w_last) w_state_next = S_APPLY;
      S_APPLY: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (panic) w_state_next = S_IDLE;
  end

  assign w_accept    = ev_valid & ev_ready;
  assign w_last      = (r_idx == idx_t'(VOICES - 1));
  assign w_scan_gate = r_gate[r_idx];
  assign w_scan_hit  = w_scan_gate && (r_key[r_idx] == r_ev_key);

  // ---------------- event latch and sequential scan ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_ev_on     <= 1'b0;
      r_ev_key    <= '0;
      r_ev_inc    <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_old_vld   <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
    end else if (panic) begin
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ev_on     <= ev_on;
            r_ev_key    <= ev_key;
            r_ev_inc    <= ev_increment;
            r_idx       <= '0;
            r_match_vld <= 1'b0;
            r_free_vld  <= 1'b0;
            r_old_vld   <= 1'b0;
            r_old_age   <= '0;
          end
        end
        S_SCAN: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_scan_hit && !r_match_vld) begin
            r_match_vld <= 1'b1;
            r_match_idx <= r_idx;
          end
          if (!w_scan_gate && !r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
          end
          // Strict '>' keeps the lowest index on equal ages.
          if (w_scan_gate && (!r_old_vld || (r_age[r_idx] > r_old_age))) begin
            r_old_vld <= 1'b1;
            r_old_idx <= r_idx;
            r_old_age <= r_age[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- apply ----------------
  assign w_tgt        = r_match_vld ? r_match_idx : (r_free_vld ? r_free_idx : r_old_idx);
  assign w_steal_path = ~r_match_vld & ~r_free_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate   <= '0;
      r_trig   <= '0;
      r_steal  <= 1'b0;
      r_active <= '0;
      // NOTE: the voice tables are reset because downstream voices must start silent at 0 Hz.
      for (int v = 0; v < VOICES; v++) begin
        r_key[v] <= '0;
        r_inc[v] <= '0;
        r_age[v] <= '0;
      end
    end else begin
      r_trig   <= '0;
      r_steal  <= 1'b0;
      r_active <= popcount(r_gate);
      if (panic) begin
        r_gate <= '0;
      end else if (r_state == S_APPLY) begin
        if (r_ev_on) begin
          r_steal <= w_steal_path;
          for (int v = 0; v < VOICES; v++) begin
            if (idx_t'(v) == w_tgt) begin
              r_gate[v] <= 1'b1;
              r_trig[v] <= 1'b1;
              r_key[v]  <= r_ev_key;
              r_inc[v]  <= r_ev_inc;
              r_age[v]  <= '0;
            end else if (r_gate[v] && (r_age[v] != AGE_MAX)) begin
              r_age[v] <= r_age[v] + 1'b1;
            end
          end
        end else if (r_match_vld) begin
          // Key and increment stay so the release phase keeps its pitch.
          r_gate[r_match_idx] <= 1'b0;
        end
      end
    end
  end

  assign gate         = r_gate;
  assign trig         = r_trig;
  assign steal        = r_steal;
  assign active_count = r_active;

  for (genvar v = 0; v < VOICES; v++) begin : g_flat
    assign voice_increment[v*INCBITS +: INCBITS] = r_inc[v];
    assign voice_key[v*KEYBITS +: KEYBITS]       = r_key[v];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (VOICES=4): allocation, steal,
// retrigger, note-off, panic mid-scan and asynchronous reset mid-scan.
module tb_voice_allocator;

  localparam int VOICES  = 4;
  localparam int KEYBITS = 4;
  localparam int INCBITS = 16;
  localparam int AGEBITS = 4;

  logic                      clk;
  logic                      rst;
  logic                      ev_valid;
  logic                      ev_ready;
  logic                      ev_on;
  logic [KEYBITS-1:0]        ev_key;
  logic [INCBITS-1:0]        ev_increment;
  logic                      panic;
  logic [VOICES-1:0]         gate;
  logic [VOICES-1:0]         trig;
  logic [VOICES*INCBITS-1:0] voice_increment;
  logic [VOICES*KEYBITS-1:0] voice_key;
  logic                      steal;
  logic [3:0]                active_count;

  int n_cmp = 0;
  int n_bad = 0;

  voice_allocator #(
    .VOICES (VOICES),
    .KEYBITS(KEYBITS),
    .INCBITS(INCBITS),
    .AGEBITS(AGEBITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_key         (ev_key),
    .ev_increment   (ev_increment),
    .panic          (panic),
    .gate           (gate),
    .trig           (trig),
    .voice_increment(voice_increment),
    .voice_key      (voice_key),
    .steal          (steal),
    .active_count   (active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INCBITS-1:0] inc_of(input int v);
    return voice_increment[v*INCBITS +: INCBITS];
  endfunction

  function automatic logic [KEYBITS-1:0] key_of(input int v);
    return voice_key[v*KEYBITS +: KEYBITS];
  endfunction

  // Waits (bounded) for ready, takes the accept edge, then scrambles the event inputs.
  task automatic accept_event(input logic on, input logic [KEYBITS-1:0] key,
                              input logic [INCBITS-1:0] inc);
    ev_valid     = 1'b1;
    ev_on        = on;
    ev_key       = key;
    ev_increment = inc;
    for (int n = 0; n < 32 && !ev_ready; n++) tick();
    check("ready_before_accept", ev_ready, 1);
    tick();
    ev_valid     = 1'b0;
    ev_on        = ~on;
    ev_key       = ~key;
    ev_increment = 16'hFFFF;
    check("ready_low_in_scan", ev_ready, 0);
  endtask

  // VOICES scan edges, then the apply edge; returns with trig/steal visible.
  task automatic finish_event();
    repeat (VOICES) tick();
    check("trig_before_apply", trig, 0);
    tick();
  endtask

  task automatic do_event(input logic on, input logic [KEYBITS-1:0] key,
                          input logic [INCBITS-1:0] inc);
    accept_event(on, key, inc);
    finish_event();
  endtask

  logic [VOICES-1:0] seen_trig;

  initial begin
    rst          = 1'b1;
    ev_valid     = 1'b0;
    ev_on        = 1'b0;
    ev_key       = '0;
    ev_increment = '0;
    panic        = 1'b0;
    #12;
    check("rst_gate",   gate, 0);
    check("rst_trig",   trig, 0);
    check("rst_steal",  steal, 0);
    check("rst_active", active_count, 0);
    check("rst_ready",  ev_ready, 1);
    check("rst_key",    voice_key, 0);
    check("rst_inc",    voice_increment, 0);
    rst = 1'b0;
    tick();

    // Four note-ons fill voices 0..3 in order.
    for (int i = 0; i < VOICES; i++) begin
      do_event(1'b1, 4'(i + 1), 16'((i + 1) * 256));
      check("alloc_trig",  trig, 64'(1 << i));
      check("alloc_gate",  gate, 64'((1 << (i + 1)) - 1));
      check("alloc_steal", steal, 0);
    end
    tick();
    check("trig_one_cycle", trig, 0);
    check("active_full",    active_count, 4);
    check("keys_full",      voice_key, 16'h4321);
    check("incs_full",      voice_increment, 64'h0400_0300_0200_0100);

    // Ages now 3,2,1,0: voice 0 is stolen first.
    do_event(1'b1, 4'd5, 16'h0500);
    check("steal1_pulse", steal, 1);
    check("steal1_trig",  trig, 4'b0001);
    check("steal1_key",   key_of(0), 5);
    check("steal1_inc",   inc_of(0), 16'h0500);
    check("steal1_gate",  gate, 4'hF);
    tick();
    check("steal1_pulse_end", steal, 0);
    check("steal1_trig_end",  trig, 0);

    // Ages now 0,3,2,1: voice 1 is next.
    do_event(1'b1, 4'd6, 16'h0600);
    check("steal2_pulse", steal, 1);
    check("steal2_trig",  trig, 4'b0010);
    check("steal2_keys",  voice_key, 16'h4365);

    // Retrigger key 3 on voice 2.
    do_event(1'b1, 4'd3, 16'h0333);
    check("retrig_trig",  trig, 4'b0100);
    check("retrig_steal", steal, 0);
    check("retrig_gate",  gate, 4'hF);
    check("retrig_incs",  voice_increment, 64'h0400_0333_0600_0500);

    // Panic two cycles into the scan of a note-on.
    accept_event(1'b1, 4'd11, 16'h0BBB);
    tick();
    tick();
    panic = 1'b1;
    #1;
    check("panic_ready_low", ev_ready, 0);
    tick();
    check("panic_gate", gate, 0);
    check("panic_trig", trig, 0);
    tick();
    check("panic_ready_held", ev_ready, 0);
    panic = 1'b0;
    #1;
    check("ready_after_panic", ev_ready, 1);
    seen_trig = '0;
    repeat (VOICES + 2) begin
      tick();
      seen_trig |= trig;
    end
    check("panic_no_trig",   seen_trig, 0);
    check("panic_gate_hold", gate, 0);
    check("panic_active",    active_count, 0);
    check("panic_keys_kept", voice_key, 16'h4365);
    check("panic_incs_kept", voice_increment, 64'h0400_0333_0600_0500);

    // Refill from silence: all free, so voices 0..3 in order again.
    for (int i = 0; i < VOICES; i++) begin
      do_event(1'b1, 4'(i + 1), 16'((i + 1) * 256));
      check("refill_trig", trig, 64'(1 << i));
    end
    tick();
    check("refill_active", active_count, 4);

    // Note-off key 2 clears voice 1 only.
    do_event(1'b0, 4'd2, 16'h0999);
    check("off_gate",  gate, 4'b1101);
    check("off_trig",  trig, 0);
    check("off_steal", steal, 0);
    check("off_inc",   inc_of(1), 16'h0200);
    tick();
    check("off_active", active_count, 3);

    // Unmapped note-off changes nothing.
    do_event(1'b0, 4'd9, 16'h0000);
    check("off9_gate", gate, 4'b1101);
    check("off9_trig", trig, 0);
    check("off9_keys", voice_key, 16'h4321);

    // Lowest free voice is reused.
    do_event(1'b1, 4'd8, 16'h0800);
    check("reuse_trig", trig, 4'b0010);
    check("reuse_gate", gate, 4'hF);
    check("reuse_keys", voice_key, 16'h4381);
    check("reuse_inc",  inc_of(1), 16'h0800);

    // Asynchronous reset between edges during SCAN.
    accept_event(1'b1, 4'd12, 16'h0CCC);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_gate",   gate, 0);
    check("arst_trig",   trig, 0);
    check("arst_steal",  steal, 0);
    check("arst_active", active_count, 0);
    check("arst_ready",  ev_ready, 1);
    check("arst_key",    voice_key, 0);
    check("arst_inc",    voice_increment, 0);
    #1;
    rst = 1'b0;
    do_event(1'b1, 4'd10, 16'h0A00);
    check("post_rst_trig", trig, 4'b0001);
    check("post_rst_gate", gate, 4'b0001);
    check("post_rst_key",  key_of(0), 10);
    check("post_rst_inc",  inc_of(0), 16'h0A00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
